// File: rtl/f124_stim_gen.sv
// f124_stim_gen: sweeps all 16 input vectors of a 4-input function, holds each
// for DWELL cycles, captures the returned result into a 16-bit truth table and
// counts the ones. Supports abort and asynchronous reset mid-sweep.
module f124_stim_gen #(
    parameter int DWELL = 2              // cycles each vector is held, 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        out,
    output logic [3:0]  vec_idx,
    output logic [15:0] truth,
    output logic [4:0]  ones_cnt,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_DWELL = 4'(DWELL - 1);

    state_t     state, state_nxt;
    logic [3:0] dwell_cnt;
    logic       cap;

    // Capture edge of the current vector; abort wins over a coinciding capture.
    assign cap = (state == DRIVE) && !abort && (dwell_cnt == LAST_DWELL);

    // The vector bits come straight from the vec_idx flops, so they are registered.
    assign {a, b, c, d} = vec_idx;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = DRIVE;
            end
            DRIVE: begin
                busy = 1'b1;
                if (abort)                          state_nxt = IDLE;
                else if (cap && vec_idx == 4'd15)   state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep datapath: vector index, dwell counter, truth table and ones count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx   <= 4'd0;
            dwell_cnt <= 4'd0;
            truth     <= 16'h0000;
            ones_cnt  <= 5'd0;
        end else if (state == IDLE && start) begin
            vec_idx   <= 4'd0;
            dwell_cnt <= 4'd0;
            truth     <= 16'h0000;
            ones_cnt  <= 5'd0;
        end else if (state == DRIVE && !abort) begin
            if (cap) begin
                truth[vec_idx] <= out;
                // At most 16 captures per sweep, so the guard only protects 5'd16.
                if (out && ones_cnt != 5'd16) ones_cnt <= ones_cnt + 5'd1;
                dwell_cnt <= 4'd0;
                if (vec_idx != 4'd15) vec_idx <= vec_idx + 4'd1;
            end else begin
                dwell_cnt <= dwell_cnt + 4'd1;
            end
        end
    end

endmodule
